// File: rtl/sram_arbiter.sv
// Pixel SRAM arbiter: display reads always win; host writes are queued and drained in blanking.
// Optional statistics outputs are enabled by defining ARB_STATS_EN.
module sram_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        reset,
`ifdef ARB_STATS_EN
    output logic [15:0] stat_writes,
    output logic [15:0] stat_aborts,
`endif
    input  logic        disp_req,
    input  logic [7:0]  disp_x,
    input  logic [7:0]  disp_y,
    output logic [11:0] disp_data,
    output logic        disp_valid,
    input  logic        wr_valid,
    input  logic [7:0]  wr_x,
    input  logic [7:0]  wr_y,
    input  logic [11:0] wr_data,
    output logic        wr_ready,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_x,
    output logic [7:0]  mem_y,
    output logic [11:0] mem_wdata,
    input  logic [11:0] mem_rdata,
    input  logic        mem_wack,
    output logic        wr_starved
);

    localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [11:0] data;
    } wr_entry_t;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t              state, next_state;
    wr_entry_t           fifo_mem [FIFO_DEPTH];
    wr_entry_t           head;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count, count_next;
    logic [STARVE_W-1:0] starve_cnt;
    logic                push, pop, abort;

    assign push      = wr_valid & wr_ready;
    assign head      = fifo_mem[rd_ptr];
    assign disp_data = disp_valid ? mem_rdata : 12'h000;

    always_comb begin
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Entry storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{x: wr_x, y: wr_y, data: wr_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            wr_ready   <= 1'b0;
            disp_valid <= 1'b0;
            state      <= IDLE;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count      <= count_next;
            wr_ready   <= (count_next != CNT_W'(FIFO_DEPTH));
            disp_valid <= disp_req;
            state      <= next_state;
        end
    end

    // Write FSM and SRAM port mux; a display request pre-empts any write in the same cycle.
    always_comb begin
        next_state = state;
        mem_rd     = disp_req;
        mem_wr     = 1'b0;
        mem_x      = 8'h00;
        mem_y      = 8'h00;
        mem_wdata  = 12'h000;
        pop        = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if ((count != '0) && !disp_req) next_state = WRITE;
            end
            WRITE: begin
                if (!disp_req) begin
                    mem_wr    = 1'b1;
                    mem_x     = head.x;
                    mem_y     = head.y;
                    mem_wdata = head.data;
                end
                if (mem_wack) begin
                    pop        = 1'b1;
                    next_state = IDLE;
                end else if (disp_req) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (disp_req) begin
            mem_x = disp_x;
            mem_y = disp_y;
        end
    end

    // Starvation watchdog: counts cycles with queued data but no completed write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            wr_starved <= 1'b0;
        end else if (pop) begin
            starve_cnt <= '0;
            wr_starved <= 1'b0;
        end else if (count == '0) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
            if (starve_cnt == STARVE_W'(STARVE_LIMIT - 1)) wr_starved <= 1'b1;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_writes <= 16'h0000;
            stat_aborts <= 16'h0000;
        end else begin
            if (pop)   stat_writes <= stat_writes + 16'd1;
            if (abort) stat_aborts <= stat_aborts + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: vector table for single-cycle behaviour plus hand sequences.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        disp_req;
    logic [7:0]  disp_x, disp_y;
    logic [11:0] disp_data;
    logic        disp_valid;
    logic        wr_valid;
    logic [7:0]  wr_x, wr_y;
    logic [11:0] wr_data;
    logic        wr_ready;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_x, mem_y;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic        mem_wack;
    logic        wr_starved;

    int checks   = 0;
    int failures = 0;

    sram_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(16)) dut (
        .clk(clk), .reset(reset),
        .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .wr_valid(wr_valid), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .wr_ready(wr_ready),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_x(mem_x), .mem_y(mem_y),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_wack(mem_wack),
        .wr_starved(wr_starved)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dreq;
        logic [7:0]  dx, dy;
        logic        wv;
        logic [7:0]  wx, wy;
        logic [11:0] wd;
        logic [11:0] rdata;
        logic        wack;
        logic        e_rd, e_wr;
        logic [7:0]  e_mx, e_my;
        logic [11:0] e_wd;
        logic        e_dv;
        logic [11:0] e_dd;
        logic        e_rdy;
    } vec_t;

    vec_t      vecs [21];
    logic [27:0] done_q [$];

    function automatic vec_t mk(logic dreq, logic [7:0] dx, logic [7:0] dy,
                                logic wv, logic [7:0] wx, logic [7:0] wy, logic [11:0] wd,
                                logic [11:0] rdata, logic wack,
                                logic e_rd, logic e_wr, logic [7:0] e_mx, logic [7:0] e_my,
                                logic [11:0] e_wd, logic e_dv, logic [11:0] e_dd, logic e_rdy);
        vec_t v;
        v.dreq = dreq; v.dx = dx; v.dy = dy;
        v.wv = wv; v.wx = wx; v.wy = wy; v.wd = wd;
        v.rdata = rdata; v.wack = wack;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_mx = e_mx; v.e_my = e_my;
        v.e_wd = e_wd; v.e_dv = e_dv; v.e_dd = e_dd; v.e_rdy = e_rdy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        disp_req = 1'b0; disp_x = 8'h00; disp_y = 8'h00;
        wr_valid = 1'b0; wr_x = 8'h00; wr_y = 8'h00; wr_data = 12'h000;
        mem_rdata = 12'h000; mem_wack = 1'b0;
    endtask

    // Write-ack responder: acks one cycle after mem_wr first appears, logs completed writes.
    task automatic drain(input int ncyc, output int ndone);
        logic last;
        last  = 1'b0;
        ndone = 0;
        for (int c = 0; c < ncyc; c++) begin
            mem_wack = last;
            #1;
            if (mem_wr && mem_wack) begin
                done_q.push_back({mem_x, mem_y, mem_wdata});
                ndone++;
            end
            last = mem_wr && !mem_wack;
            tick();
        end
        mem_wack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int ndone;
        // Read, blank drain, abort/retry and wack-with-disp_req cycles.
        vecs[0]  = mk(1,5,7,    0,0,0,12'h000, 12'h123,0, 1,0,5,7,12'h000,   0,12'h000,1);
        vecs[1]  = mk(0,0,0,    1,3,4,12'hF00, 12'hABC,0, 0,0,0,0,12'h000,   1,12'hABC,1);
        vecs[2]  = mk(0,0,0,    1,9,9,12'h0F0, 12'h000,0, 0,0,0,0,12'h000,   0,12'h000,1);
        vecs[3]  = mk(0,0,0,    0,0,0,12'h000, 12'h000,0, 0,1,3,4,12'hF00,   0,12'h000,1);
        vecs[4]  = mk(0,0,0,    0,0,0,12'h000, 12'h000,1, 0,1,3,4,12'hF00,   0,12'h000,1);
        vecs[5]  = mk(0,0,0,    0,0,0,12'h000, 12'h000,0, 0,0,0,0,12'h000,   0,12'h000,1);
        vecs[6]  = mk(0,0,0,    0,0,0,12'h000, 12'h000,0, 0,1,9,9,12'h0F0,   0,12'h000,1);
        vecs[7]  = mk(0,0,0,    0,0,0,12'h000, 12'h000,1, 0,1,9,9,12'h0F0,   0,12'h000,1);
        vecs[8]  = mk(0,0,0,    1,1,2,12'h555, 12'h000,0, 0,0,0,0,12'h000,   0,12'h000,1);
        vecs[9]  = mk(0,0,0,    0,0,0,12'h000, 12'h000,0, 0,0,0,0,12'h000,   0,12'h000,1);
        vecs[10] = mk(0,0,0,    0,0,0,12'h000, 12'h000,0, 0,1,1,2,12'h555,   0,12'h000,1);
        vecs[11] = mk(1,20,30,  0,0,0,12'h000, 12'h000,0, 1,0,20,30,12'h000, 0,12'h000,1);
        vecs[12] = mk(0,0,0,    0,0,0,12'h000, 12'h777,0, 0,0,0,0,12'h000,   1,12'h777,1);
        vecs[13] = mk(0,0,0,    0,0,0,12'h000, 12'h000,1, 0,1,1,2,12'h555,   0,12'h000,1);
        vecs[14] = mk(0,0,0,    0,0,0,12'h000, 12'h000,0, 0,0,0,0,12'h000,   0,12'h000,1);
        vecs[15] = mk(0,0,0,    1,6,6,12'h0AA, 12'h000,0, 0,0,0,0,12'h000,   0,12'h000,1);
        vecs[16] = mk(0,0,0,    0,0,0,12'h000, 12'h000,0, 0,0,0,0,12'h000,   0,12'h000,1);
        vecs[17] = mk(0,0,0,    0,0,0,12'h000, 12'h000,0, 0,1,6,6,12'h0AA,   0,12'h000,1);
        vecs[18] = mk(1,2,3,    0,0,0,12'h000, 12'h000,1, 1,0,2,3,12'h000,   0,12'h000,1);
        vecs[19] = mk(0,0,0,    0,0,0,12'h000, 12'h456,0, 0,0,0,0,12'h000,   1,12'h456,1);
        vecs[20] = mk(0,0,0,    0,0,0,12'h000, 12'h000,0, 0,0,0,0,12'h000,   0,12'h000,1);

        // Reset values while held, then wr_ready rising one edge after release.
        idle_inputs();
        reset = 1'b0;
        #1;
        tick();
        tick();
        chk("rst_disp_data",  32'(disp_data),  32'h0);
        chk("rst_disp_valid", 32'(disp_valid), 32'h0);
        chk("rst_wr_ready",   32'(wr_ready),   32'h0);
        chk("rst_mem_rd",     32'(mem_rd),     32'h0);
        chk("rst_mem_wr",     32'(mem_wr),     32'h0);
        chk("rst_mem_x",      32'(mem_x),      32'h0);
        chk("rst_mem_y",      32'(mem_y),      32'h0);
        chk("rst_mem_wdata",  32'(mem_wdata),  32'h0);
        chk("rst_wr_starved", 32'(wr_starved), 32'h0);
        reset = 1'b1;
        #1;
        chk("rel_wr_ready_before_edge", 32'(wr_ready), 32'h0);
        tick();
        chk("rel_wr_ready_after_edge", 32'(wr_ready), 32'h1);

        for (int i = 0; i < 21; i++) begin
            disp_req = vecs[i].dreq; disp_x = vecs[i].dx; disp_y = vecs[i].dy;
            wr_valid = vecs[i].wv; wr_x = vecs[i].wx; wr_y = vecs[i].wy; wr_data = vecs[i].wd;
            mem_rdata = vecs[i].rdata; mem_wack = vecs[i].wack;
            #1;
            chk($sformatf("v%0d_mem_rd", i),     32'(mem_rd),     32'(vecs[i].e_rd));
            chk($sformatf("v%0d_mem_wr", i),     32'(mem_wr),     32'(vecs[i].e_wr));
            chk($sformatf("v%0d_mem_x", i),      32'(mem_x),      32'(vecs[i].e_mx));
            chk($sformatf("v%0d_mem_y", i),      32'(mem_y),      32'(vecs[i].e_my));
            chk($sformatf("v%0d_mem_wdata", i),  32'(mem_wdata),  32'(vecs[i].e_wd));
            chk($sformatf("v%0d_disp_valid", i), 32'(disp_valid), 32'(vecs[i].e_dv));
            chk($sformatf("v%0d_disp_data", i),  32'(disp_data),  32'(vecs[i].e_dd));
            chk($sformatf("v%0d_wr_ready", i),   32'(wr_ready),   32'(vecs[i].e_rdy));
            tick();
        end
        idle_inputs();

        // FIFO full under continuous display demand: fifth offer is dropped.
        disp_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_x = 8'(10 + i); wr_y = 8'(20 + i); wr_data = 12'(12'h100 + i);
            #1;
            chk($sformatf("full_wr_ready_%0d", i), 32'(wr_ready), (i < 4) ? 32'h1 : 32'h0);
            chk($sformatf("full_mem_wr_%0d", i), 32'(mem_wr), 32'h0);
            tick();
        end
        wr_valid = 1'b0;
        disp_req = 1'b0;
        done_q.delete();
        drain(20, ndone);
        chk("full_writes_issued", 32'(ndone), 32'd4);
        for (int i = 0; i < 4; i++) begin
            logic [27:0] got;
            got = (i < done_q.size()) ? done_q[i] : 28'h0;
            chk($sformatf("full_write_%0d", i), 32'(got),
                32'({8'(10 + i), 8'(20 + i), 12'(12'h100 + i)}));
        end
        chk("full_wr_ready_after_drain", 32'(wr_ready), 32'h1);

        // Starvation: one queued entry held off by display for 20 cycles.
        disp_req = 1'b1;
        wr_valid = 1'b1; wr_x = 8'd7; wr_y = 8'd8; wr_data = 12'hABC;
        tick();
        wr_valid = 1'b0;
        repeat (15) tick();
        chk("starve_cycle15", 32'(wr_starved), 32'h0);
        tick();
        chk("starve_cycle16", 32'(wr_starved), 32'h1);
        repeat (4) tick();
        chk("starve_sticky", 32'(wr_starved), 32'h1);
        disp_req = 1'b0;
        tick();
        chk("starve_write_mem_wr", 32'(mem_wr), 32'h1);
        chk("starve_write_data", 32'(mem_wdata), 32'hABC);
        chk("starve_before_pop", 32'(wr_starved), 32'h1);
        mem_wack = 1'b1;
        tick();
        mem_wack = 1'b0;
        #1;
        chk("starve_cleared", 32'(wr_starved), 32'h0);
        chk("starve_idle_after_pop", 32'(mem_wr), 32'h0);

        // Reset during a write: strobe drops immediately and the entry is discarded.
        wr_valid = 1'b1; wr_x = 8'd1; wr_y = 8'd1; wr_data = 12'h111;
        tick();
        wr_valid = 1'b0;
        tick();
        chk("rstmid_mem_wr_before", 32'(mem_wr), 32'h1);
        reset = 1'b0;
        #1;
        chk("rstmid_mem_wr_async", 32'(mem_wr), 32'h0);
        chk("rstmid_wr_ready", 32'(wr_ready), 32'h0);
        tick();
        reset = 1'b1;
        tick();
        chk("rstmid_wr_ready_back", 32'(wr_ready), 32'h1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("rstmid_no_write_%0d", i), 32'(mem_wr), 32'h0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
